// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Single-outstanding load/store unit bridging the MEM stage to a
//            byte-addressed SRAM (RV32I widths, sign/zero extension, faults).
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [4:0]          r_rd;
  logic                r_fault;
  logic [3:0]          r_mem_w_en;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic [4:0]          r_resp_rd;
  logic                r_resp_fault;

  logic                w_addr_oob;
  logic                w_bad_load;
  logic                w_bad_store;
  logic                w_fault;
  logic [3:0]          w_store_en;
  logic [31:0]         w_load_data;

  // Any address bit beyond the SRAM window makes the request illegal.
  assign w_addr_oob  = |req_addr[31:ADDR_W];
  assign w_bad_load  = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
  assign w_bad_store = (req_funct3 > 3'd2);
  assign w_fault     = w_addr_oob || (req_we ? w_bad_store : w_bad_load);

  always_comb begin
    w_store_en = 4'b0000;
    case (req_funct3)
      3'd0:    w_store_en = 4'b0001;
      3'd1:    w_store_en = 4'b0011;
      3'd2:    w_store_en = 4'b1111;
      default: w_store_en = 4'b0000;
    endcase
  end

  always_comb begin
    w_load_data = mem_rdata;
    case (r_funct3)
      3'd0:    w_load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    w_load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    w_load_data = {24'd0, mem_rdata[7:0]};
      3'd5:    w_load_data = {16'd0, mem_rdata[15:0]};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_rd         <= 5'd0;
      r_fault      <= 1'b0;
      r_mem_w_en   <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_rd    <= 5'd0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_rd        <= req_rd;
            r_fault     <= w_fault;
            r_mem_addr  <= req_addr[ADDR_W-1:0];
            r_mem_wdata <= req_wdata;
            // Write strobe is launched with the state change so it is live for exactly the ACCESS cycle.
            r_mem_w_en  <= (req_we && !w_fault) ? w_store_en : 4'b0000;
            r_req_ready <= 1'b0;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_w_en   <= 4'b0000;
          r_resp_valid <= 1'b1;
          r_resp_data  <= (r_we || r_fault) ? 32'd0 : w_load_data;
          r_resp_rd    <= r_rd;
          r_resp_fault <= r_fault;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_mem_w_en   <= 4'b0000;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_w_en   = r_mem_w_en;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign resp_fault = r_resp_fault;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Scoreboard bench for lsu_mem_ctrl with a byte-array SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic [3:0]    mem_w_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic [4:0]    resp_rd;
  logic          resp_fault;

  lsu_mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  // Physical SRAM seen by the DUT, and the reference memory used for expectations.
  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  assign mem_rdata = {sram[mem_addr + 16'd3], sram[mem_addr + 16'd2],
                      sram[mem_addr + 16'd1], sram[mem_addr]};

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (mem_w_en[j] === 1'b1) sram[mem_addr + AW'(j)] <= mem_wdata[8*j +: 8];
  end

  int wen_cycles = 0;
  always @(negedge clk) if (mem_w_en !== 4'b0000) wen_cycles++;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } resp_t;
  resp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
      end
    end
  end

  // Reference model: architectural effect of one request on ref_mem and its response.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] data,
                       output logic fault, output logic [3:0] wen);
    int unsigned a, nbytes, word, b, h;
    a = addr % 65536;
    fault = (addr / 65536 != 0) || (we ? (f3 > 2) : (f3 == 3 || f3 >= 6));
    data = 32'd0;
    wen = 4'b0000;
    if (fault) return;
    if (we) begin
      nbytes = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
      for (int i = 0; i < int'(nbytes); i++)
        ref_mem[(a + i) % 65536] = 8'((wdata >> (8 * i)) % 256);
      wen = 4'((1 << nbytes) - 1);
    end else begin
      word = 0;
      for (int i = 0; i < 4; i++)
        word = word + (int'(ref_mem[(a + i) % 65536]) << (8 * i));
      b = word % 256;
      h = word % 65536;
      case (f3)
        3'd0:    data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        3'd1:    data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        3'd4:    data = b;
        3'd5:    data = h;
        default: data = word;
      endcase
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int hold);
    int t;
    int w0;
    resp_t e;
    logic [3:0] exp_wen;
    logic [31:0] s_data;
    logic [4:0] s_rd;
    logic s_fault;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model(we, f3, addr, wdata, e.data, e.fault, exp_wen);
    e.rd = rd;
    exp_q.push_back(e);
    w0 = wen_cycles;
    @(posedge clk); #1;               // accept edge; now in ACCESS
    req_valid = 1'b0;
    chk("access_req_ready", {31'd0, req_ready}, 32'd0);
    chk("access_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("access_w_en", {28'd0, mem_w_en}, {28'd0, exp_wen});
    if (!e.fault) chk("access_addr", {16'd0, mem_addr}, addr % 65536);
    if (exp_wen != 4'b0000) chk("access_wdata", mem_wdata, wdata);
    @(posedge clk); #1;               // now in RESP
    chk("resp_latency", {31'd0, resp_valid}, 32'd1);
    chk("resp_w_en_idle", {28'd0, mem_w_en}, 32'd0);
    s_data = resp_data; s_rd = resp_rd; s_fault = resp_fault;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_data", resp_data, s_data);
      chk("hold_rd", {27'd0, resp_rd}, {27'd0, s_rd});
      chk("hold_fault", {31'd0, resp_fault}, {31'd0, s_fault});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;               // response handshake edge
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("w_en_cycles", wen_cycles - w0, (exp_wen != 4'b0000) ? 1 : 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addr, hi;
    int w0;
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_w_en", {28'd0, mem_w_en}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 5'd1, 0);  // SW
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 5'd2, 0);          // LW
    do_req(1'b0, 3'd0, 32'h0000_0013, 32'h0, 5'd3, 0);          // LB
    do_req(1'b0, 3'd4, 32'h0000_0013, 32'h0, 5'd4, 0);          // LBU
    do_req(1'b0, 3'd1, 32'h0000_0010, 32'h0, 5'd5, 0);          // LH
    do_req(1'b0, 3'd5, 32'h0000_0010, 32'h0, 5'd6, 0);          // LHU
    do_req(1'b1, 3'd0, 32'h0000_0011, 32'h0000_00AA, 5'd8, 0);  // SB
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 5'd9, 0);          // LW -> DEADAAEF
    chk("sram_word_after_sb", {sram[19], sram[18], sram[17], sram[16]}, 32'hDEAD_AAEF);
    do_req(1'b0, 3'd2, 32'h0001_0000, 32'h0, 5'd10, 0);         // out-of-range load
    do_req(1'b1, 3'd3, 32'h0000_0020, 32'h1234_5678, 5'd11, 0); // illegal store width
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 5'd7, 4);          // back-pressure
    do_req(1'b0, 3'd0, 32'h0000_0012, 32'h0, 5'd12, 0);         // accepted right after

    // Abort a load while it sits in RESP.
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_rd = 5'd13;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_resp", {31'd0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_data", resp_data, 32'd0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    w0 = wen_cycles;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_w_en", wen_cycles - w0, 32'd0);

    for (int n = 0; n < 150; n++) begin
      addr = 32'h0000_0100 + $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) begin
        hi = $urandom_range(1, 65535);
        addr = (hi << 16) | addr;
      end
      do_req(1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom,
             5'($urandom), $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
